// File: rtl/tcu_priv_reg_arbiter.sv
// Round-robin arbiter sharing the TCU privileged register port among NUM_REQ requesters,
// with per-requester locking for atomic multi-access sequences and one-cycle read return routing.
module tcu_priv_reg_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 64,
  parameter int BSEL_SIZE = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_en_i,
  input  logic [NUM_REQ-1:0]             req_lock_i,
  input  logic [NUM_REQ*BSEL_SIZE-1:0]   req_wben_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]             req_stall_o,
  output logic [NUM_REQ-1:0]             req_rvalid_o,
  output logic [DATA_SIZE-1:0]           req_rdata_o,
  output logic                           reg_en_o,
  output logic [BSEL_SIZE-1:0]           reg_wben_o,
  output logic [ADDR_SIZE-1:0]           reg_addr_o,
  output logic [DATA_SIZE-1:0]           reg_wdata_o,
  input  logic [DATA_SIZE-1:0]           reg_rdata_i,
  input  logic                           reg_stall_i,
  output logic [NUM_REQ-1:0]             lock_owner_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  localparam logic [0:0] S_FREE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]         state_q,    state_d;
  logic [IDX_W-1:0]   owner_q,    owner_d;
  logic [IDX_W-1:0]   last_q,     last_d;
  logic               hold_q,     hold_d;
  logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;
  logic [NUM_REQ-1:0] rd_pend_q,  rd_pend_d;

  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] owner_oh;
  logic [SUM_W-1:0]   scan_sum;
  logic [IDX_W-1:0]   scan_idx;
  logic               accept;
  logic               grant_is_read;

  logic [BSEL_SIZE-1:0] mux_wben;
  logic [ADDR_SIZE-1:0] mux_addr;
  logic [DATA_SIZE-1:0] mux_wdata;
  logic [NUM_REQ-1:0]   stall_vec;

  // A stalled free-state grant is held so a newly asserting requester cannot
  // steal the port while the register file is still busy with this one.
  // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (state_q == S_LOCKED) begin
      grant_vld = req_en_i[owner_q];
      grant_idx = owner_q;
    end else if (hold_q && req_en_i[hold_idx_q]) begin
      grant_vld = 1'b1;
      grant_idx = hold_idx_q;
    end else begin
      // Scan farthest to nearest so the nearest requester after last_q is the final winner.
      for (int k = NUM_REQ; k >= 1; k--) begin
        scan_sum = {1'b0, last_q} + SUM_W'(k);
        if (scan_sum >= SUM_W'(NUM_REQ)) scan_sum = scan_sum - SUM_W'(NUM_REQ);
        scan_idx = scan_sum[IDX_W-1:0];
        if (req_en_i[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_idx;
  assign owner_oh = NUM_REQ'(1) << owner_q;

  always_comb begin
    mux_wben  = '0;
    mux_addr  = '0;
    mux_wdata = '0;
    stall_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_idx == IDX_W'(i)) begin
        mux_wben     = req_wben_i[i*BSEL_SIZE +: BSEL_SIZE];
        mux_addr     = req_addr_i[i*ADDR_SIZE +: ADDR_SIZE];
        mux_wdata    = req_wdata_i[i*DATA_SIZE +: DATA_SIZE];
        stall_vec[i] = reg_stall_i;
      end else begin
        stall_vec[i] = req_en_i[i];
      end
    end
  end

  assign accept        = grant_vld & ~reg_stall_i;
  assign grant_is_read = (mux_wben == '0);

  assign reg_en_o     = grant_vld & ~reset_i;
  assign reg_wben_o   = reset_i ? '0 : mux_wben;
  assign reg_addr_o   = reset_i ? '0 : mux_addr;
  assign reg_wdata_o  = reset_i ? '0 : mux_wdata;
  assign req_stall_o  = reset_i ? '1 : stall_vec;
  assign req_rvalid_o = reset_i ? '0 : rd_pend_q;
  assign req_rdata_o  = reg_rdata_i;
  assign lock_owner_o = (reset_i || state_q != S_LOCKED) ? '0 : owner_oh;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_d     = 1'b0;
    hold_idx_d = hold_idx_q;
    rd_pend_d  = '0;
    if (accept) begin
      last_d = grant_idx;
      if (grant_is_read) rd_pend_d = grant_oh;
      if (state_q == S_FREE) begin
        if (req_lock_i[grant_idx]) begin
          state_d = S_LOCKED;
          owner_d = grant_idx;
        end
      end else if (!req_lock_i[owner_q]) begin
        state_d = S_FREE;
      end
    end else if (grant_vld && state_q == S_FREE) begin
      hold_d     = 1'b1;
      hold_idx_d = grant_idx;
    end
    // Abandoned lock: release and resume arbitration after the former owner.
    if (state_q == S_LOCKED && !req_en_i[owner_q] && !req_lock_i[owner_q]) begin
      state_d = S_FREE;
      last_d  = owner_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_FREE;
      owner_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      rd_pend_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_tcu_priv_reg_arbiter.sv
// Directed bench for tcu_priv_reg_arbiter: reset forcing, round-robin order, locking,
// register-file stall hold, abandoned lock and reset in the middle of a locked read.
module tb_tcu_priv_reg_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      en;
  logic [N-1:0]      lock;
  logic [N*BW-1:0]   wben;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      stall_o;
  logic [N-1:0]      rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              reg_en;
  logic [BW-1:0]     reg_wben;
  logic [AW-1:0]     reg_addr;
  logic [DW-1:0]     reg_wdata;
  logic [DW-1:0]     reg_rdata;
  logic              reg_stall;
  logic [N-1:0]      lock_owner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tcu_priv_reg_arbiter #(.NUM_REQ(N), .ADDR_SIZE(AW), .DATA_SIZE(DW), .BSEL_SIZE(BW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_en_i     (en),
    .req_lock_i   (lock),
    .req_wben_i   (wben),
    .req_addr_i   (addr),
    .req_wdata_i  (wdata),
    .req_stall_o  (stall_o),
    .req_rvalid_o (rvalid_o),
    .req_rdata_o  (rdata_o),
    .reg_en_o     (reg_en),
    .reg_wben_o   (reg_wben),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_rdata_i  (reg_rdata),
    .reg_stall_i  (reg_stall),
    .lock_owner_o (lock_owner)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h10 * (i + 1));
  endfunction

  initial begin
    reset     = 1'b1;
    en        = '1;
    lock      = '0;
    wben      = '0;
    reg_stall = 1'b0;
    reg_rdata = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = addr_of(i);
      wdata[i*DW +: DW] = 64'hA5A5_0000_0000_0000 + 64'(i);
    end

    // Reset forces outputs even with every requester asserting
    cyc();
    settle();
    check("rst_reg_en", 64'(reg_en), 64'd0);
    check("rst_stall", 64'(stall_o), 64'b111);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_lock_owner", 64'(lock_owner), 64'd0);
    check("rst_reg_addr", 64'(reg_addr), 64'd0);
    en = '0;
    cyc();
    reset = 1'b0;

    // T1 single read by requester 0
    en = 3'b001;
    settle();
    check("t1_reg_en", 64'(reg_en), 64'd1);
    check("t1_addr", 64'(reg_addr), 64'h10);
    check("t1_stall", 64'(stall_o), 64'b000);
    cyc();
    en        = '0;
    reg_rdata = 64'h1234_5678_9ABC_DEF0;
    settle();
    check("t1_rvalid", 64'(rvalid_o), 64'b001);
    check("t1_rdata", rdata_o, 64'h1234_5678_9ABC_DEF0);
    check("t1_idle_en", 64'(reg_en), 64'd0);

    // T2 round-robin after reset: 0,1,2,0,1,2
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    en    = 3'b111;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("t2_addr_%0d", k), 64'(reg_addr), 64'(addr_of(k % 3)));
      check($sformatf("t2_stall_%0d", k), 64'(stall_o), 64'(3'b111 & ~(3'b001 << (k % 3))));
      if (k > 0) check($sformatf("t2_rvalid_%0d", k), 64'(rvalid_o), 64'(3'b001 << ((k - 1) % 3)));
      cyc();
    end
    en = '0;

    // Move the round-robin pointer to requester 0
    en = 3'b001;
    cyc();

    // T3 lock: req1 read+lock then write unlock, others requesting throughout
    en      = 3'b111;
    lock[1] = 1'b1;
    settle();
    check("t3_first_addr", 64'(reg_addr), 64'h20);
    check("t3_first_stall", 64'(stall_o), 64'b101);
    check("t3_first_owner", 64'(lock_owner), 64'b000);
    cyc();
    wben[1*BW +: BW] = 8'hFF;
    lock[1]          = 1'b0;
    settle();
    check("t3_second_addr", 64'(reg_addr), 64'h20);
    check("t3_second_wben", 64'(reg_wben), 64'hFF);
    check("t3_second_wdata", reg_wdata, 64'hA5A5_0000_0000_0001);
    check("t3_second_stall", 64'(stall_o), 64'b101);
    check("t3_second_owner", 64'(lock_owner), 64'b010);
    check("t3_second_rvalid", 64'(rvalid_o), 64'b010);
    cyc();
    settle();
    check("t3_next_addr", 64'(reg_addr), 64'h30);
    check("t3_next_owner", 64'(lock_owner), 64'b000);
    check("t3_next_rvalid", 64'(rvalid_o), 64'b000);
    cyc();
    en   = '0;
    wben = '0;

    // Lock without enable in the free state is ignored
    lock = 3'b001;
    settle();
    check("lock_noen_reg_en", 64'(reg_en), 64'd0);
    cyc();
    lock = '0;
    settle();
    check("lock_noen_owner", 64'(lock_owner), 64'b000);

    // T4 register stall on req2 while req0 (next in round-robin order) asserts
    en        = 3'b100;
    reg_stall = 1'b1;
    settle();
    check("t4_s1_addr", 64'(reg_addr), 64'h30);
    check("t4_s1_stall", 64'(stall_o), 64'b100);
    cyc();
    en = 3'b101;
    settle();
    check("t4_s2_addr", 64'(reg_addr), 64'h30);
    check("t4_s2_stall", 64'(stall_o), 64'b101);
    cyc();
    settle();
    check("t4_s3_addr", 64'(reg_addr), 64'h30);
    check("t4_s3_stall", 64'(stall_o), 64'b101);
    cyc();
    reg_stall = 1'b0;
    settle();
    check("t4_acc_addr", 64'(reg_addr), 64'h30);
    check("t4_acc_stall", 64'(stall_o), 64'b001);
    cyc();
    en = 3'b001;
    settle();
    check("t4_req0_addr", 64'(reg_addr), 64'h10);
    check("t4_req0_stall", 64'(stall_o), 64'b000);
    cyc();

    // T5 abandoned lock by req0
    lock = 3'b001;
    settle();
    check("t5_lock_addr", 64'(reg_addr), 64'h10);
    cyc();
    check("t5_owner", 64'(lock_owner), 64'b001);
    en   = 3'b010;
    lock = 3'b000;
    settle();
    check("t5_drop_reg_en", 64'(reg_en), 64'd0);
    check("t5_drop_stall", 64'(stall_o), 64'b010);
    check("t5_drop_owner", 64'(lock_owner), 64'b001);
    cyc();
    settle();
    check("t5_free_owner", 64'(lock_owner), 64'b000);
    check("t5_req1_addr", 64'(reg_addr), 64'h20);
    check("t5_req1_stall", 64'(stall_o), 64'b000);
    cyc();
    en = '0;

    // T6 reset while req1 owns the lock with a read pending
    en   = 3'b010;
    lock = 3'b010;
    settle();
    check("t6_lock_addr", 64'(reg_addr), 64'h20);
    cyc();
    check("t6_owner", 64'(lock_owner), 64'b010);
    reset = 1'b1;
    en    = 3'b111;
    settle();
    check("t6_rst_rvalid", 64'(rvalid_o), 64'b000);
    check("t6_rst_owner", 64'(lock_owner), 64'b000);
    check("t6_rst_reg_en", 64'(reg_en), 64'd0);
    cyc();
    reset = 1'b0;
    lock  = '0;
    settle();
    check("t6_post_owner", 64'(lock_owner), 64'b000);
    check("t6_post_rvalid", 64'(rvalid_o), 64'b000);
    check("t6_post_addr", 64'(reg_addr), 64'h10);
    check("t6_post_stall", 64'(stall_o), 64'b110);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
